// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stream decoder.
package sc_pkg;
  localparam int INWD_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } dec_state_e;
endpackage

// File: rtl/sc_stream_decoder_window_cnt.sv
// INWD-bit window counter with synchronous clear/enable and terminal-count flag.
module window_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = &cnt_q;
endmodule

// File: rtl/sc_stream_decoder.sv
// Counts ones over a window of 2^INWD accepted stream bits and presents the
// count with a valid/ready handshake.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int INWD = INWD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_bit,
  input  logic          in_valid,
  output logic          busy,
  output logic [INWD:0] out_value,
  output logic          out_valid,
  input  logic          out_ready
);
  dec_state_e    state_q, state_d;
  logic [INWD:0] acc_q, acc_d;
  logic [INWD:0] out_value_q, out_value_d;
  logic [INWD:0] acc_sum;
  logic          cnt_clr, cnt_en, cnt_tc;
  logic [INWD-1:0] cnt_unused;

  window_cnt #(.W(INWD)) u_window_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt_unused),
    .tc  (cnt_tc)
  );

  assign acc_sum = acc_q + (INWD+1)'(in_bit);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_value_d = out_value_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_clr = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // abort outranks the last-bit completion in the same cycle
        if (abort) begin
          acc_d   = '0;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (in_valid) begin
          acc_d  = acc_sum;
          cnt_en = 1'b1;
          if (cnt_tc) begin
            out_value_d = acc_sum;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_value_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_value_q <= out_value_d;
    end
  end

  assign busy      = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_value = out_value_q;
endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder at INWD=8.
module tb_sc_stream_decoder;
  localparam int INWD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [INWD:0] out_value;
  logic          out_valid;

  int pass_cnt = 0;
  int total_cnt = 0;

  sc_stream_decoder #(.INWD(INWD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .busy      (busy),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Inputs set before step() are sampled at the edge; outputs read after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic b, output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      in_bit = b; in_valid = 1'b1;
      step();
      if (out_valid && i < n - 1) early++;
    end
    in_valid = 1'b0; in_bit = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    total_cnt++;
    if ({out_valid, busy, out_value} !== {1'b0, 1'b0, 9'd0})
      $display("FAIL reset: valid=%0b busy=%0b value=%0d want 0/0/0", out_valid, busy, out_value);
    else pass_cnt++;
  endtask

  task automatic test_all_ones();
    int early;
    do_start();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL ones_busy: busy=%0b want 1", busy);
    else pass_cnt++;
    feed(256, 1'b1, early);
    total_cnt++;
    if (early !== 0) $display("FAIL ones_early: early valid cycles=%0d want 0", early);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1 || out_value !== 9'd256)
      $display("FAIL ones_result: valid=%0b value=%0d want 1/256", out_valid, out_value);
    else pass_cnt++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || out_value !== 9'd256)
      $display("FAIL ones_handshake: valid=%0b value=%0d want 0/256", out_valid, out_value);
    else pass_cnt++;
  endtask

  task automatic test_alternating();
    int acc_bits = 0;
    int early = 0;
    int cyc = 0;
    do_start();
    while (acc_bits < 256 && cyc < 1000) begin
      in_valid = (cyc % 3 != 2);
      in_bit   = (acc_bits % 2 == 0);
      step();
      if (in_valid) acc_bits++;
      if (out_valid && acc_bits < 256) early++;
      cyc++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (early !== 0 || acc_bits != 256)
      $display("FAIL alt_early: early=%0d accepted=%0d want 0/256", early, acc_bits);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1 || out_value !== 9'd128)
      $display("FAIL alt_result: valid=%0b value=%0d want 1/128", out_valid, out_value);
    else pass_cnt++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int early, vcnt;
    do_start();
    feed(37, 1'b1, early);
    feed(219, 1'b0, early);
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      out_ready = (c == 5);
      if (out_valid === 1'b1 && out_value === 9'd37) vcnt++;
      step();
    end
    out_ready = 1'b0;
    total_cnt++;
    if (vcnt != 6) $display("FAIL bp_hold: valid&stable cycles=%0d want 6", vcnt);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_value !== 9'd37)
      $display("FAIL bp_idle: valid=%0b busy=%0b value=%0d want 0/0/37", out_valid, busy, out_value);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int early, vseen;
    do_start();
    feed(100, 1'b1, early);
    abort = 1'b1; step(); abort = 1'b0;
    vseen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) vseen++;
      step();
    end
    total_cnt++;
    if (vseen != 0 || busy !== 1'b0 || out_value !== 9'd37)
      $display("FAIL abort_idle: valid_cycles=%0d busy=%0b value=%0d want 0/0/37", vseen, busy, out_value);
    else pass_cnt++;
    do_start();
    feed(256, 1'b0, early);
    total_cnt++;
    if (out_valid !== 1'b1 || out_value !== 9'd0)
      $display("FAIL abort_restart: valid=%0b value=%0d want 1/0", out_valid, out_value);
    else pass_cnt++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_rst_and_done_start();
    int early;
    do_start();
    feed(50, 1'b1, early);
    rst = 1'b1; step(); rst = 1'b0;
    total_cnt++;
    if ({out_valid, busy, out_value} !== {1'b0, 1'b0, 9'd0})
      $display("FAIL rst_mid: valid=%0b busy=%0b value=%0d want 0/0/0", out_valid, busy, out_value);
    else pass_cnt++;
    do_start();
    feed(256, 1'b1, early);
    start = 1'b1; in_valid = 1'b1; in_bit = 1'b1; abort = 1'b1;
    step(); step();
    start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; abort = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || out_value !== 9'd256)
      $display("FAIL done_start: valid=%0b busy=%0b value=%0d want 1/0/256", out_valid, busy, out_value);
    else pass_cnt++;
    out_ready = 1'b1; step(); out_ready = 1'b0; step();
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL done_no_window: busy=%0b valid=%0b want 0/0", busy, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_abort_last();
    int early, vseen;
    do_start();
    feed(255, 1'b1, early);
    in_valid = 1'b1; in_bit = 1'b1; abort = 1'b1;
    step();
    in_valid = 1'b0; in_bit = 1'b0; abort = 1'b0;
    vseen = 0;
    for (int c = 0; c < 3; c++) begin
      if (out_valid) vseen++;
      step();
    end
    total_cnt++;
    if (vseen != 0 || busy !== 1'b0 || out_value !== 9'd256)
      $display("FAIL abort_last: valid_cycles=%0d busy=%0b value=%0d want 0/0/256", vseen, busy, out_value);
    else pass_cnt++;
    // a fresh window after the abort must start counting from zero
    do_start();
    feed(255, 1'b1, early);
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL abort_recount: valid=%0b busy=%0b want 0/1 after 255 bits", out_valid, busy);
    else pass_cnt++;
    feed(1, 1'b0, early);
    total_cnt++;
    if (out_valid !== 1'b1 || out_value !== 9'd255)
      $display("FAIL abort_recount_done: valid=%0b value=%0d want 1/255", out_valid, out_value);
    else pass_cnt++;
    rst = 1'b1; out_ready = 1'b1; step(); rst = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if ({out_valid, busy, out_value} !== {1'b0, 1'b0, 9'd0})
      $display("FAIL rst_done: valid=%0b busy=%0b value=%0d want 0/0/0", out_valid, busy, out_value);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_alternating();
    test_backpressure();
    test_abort();
    test_rst_and_done_start();
    test_abort_last();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
